quat_ncl_sync_sink: RTL and testbench
=====================================

Name: quat_ncl_sync_sink

Overview:
- Clocked consumer directly downstream of the binary+trinary quaternary adder stage.
- Receives the 1-of-4 quaternary NCL output rails and drives the completion signal back (upstream derives its enable as NOT completion).
- Detects DATA/NULL wavefronts, decodes each DATA wavefront to a 2-bit binary value, and buffers it in a FIFO with a valid/ready output.
- Bridges the clockless adder pipeline into clocked logic.

Parameters:
- SYNC_STAGES, 2, flops in the input synchronizer on each rail (min 2).
- DEPTH, 4, FIFO entries (power of 2, >=2).
- ERR_W, 8, width of the saturating illegal-code counter.

Ports:
- clk  input  1  system clock.
- init_n  input  1  asynchronous active-low reset.
- quat_in  input  4  1-of-4 NCL rails from the adder; rail i high = value i; all low = NULL.
- quat_comp  output  1  completion to upstream: 1 = DATA accepted, request NULL; 0 = NULL seen, request DATA.
- dout  output  2  decoded value at FIFO head.
- dout_valid  output  1  FIFO non-empty.
- dout_ready  input  1  consumer accepts the head entry when dout_valid & dout_ready at a rising clk edge.
- err_multi  output  1  sticky flag: a sampled code had more than one rail high.
- err_count  output  ERR_W  saturating count of illegal-code samples.

Behaviour:
- Reset (init_n=0, asynchronous):
  - Synchronizer flops and previous-sample register cleared.
  - FSM = WAIT_DATA; quat_comp=0; FIFO emptied.
  - dout=0, dout_valid=0, err_multi=0, err_count=0.
  - Release takes effect on the first rising clk edge with init_n=1.
- Reset mid-operation: all state discarded, including buffered words and a half-accepted wavefront. quat_comp drops to 0 immediately, so upstream sees a DATA request.
- Synchronizer: each rail passes through SYNC_STAGES flops; s = synced sample; p = s registered one more cycle.
- Stability rule: a code is acted on only when s == p (two consecutive equal samples). This filters rail skew and single-cycle glitches.
- FSM:
  - WAIT_DATA (quat_comp=0):
    - If s==p, s is one-hot, and the FIFO is not full: push index(s), set quat_comp=1, go to WAIT_NULL.
    - If s==p, s is one-hot, and the FIFO is full: stay. Upstream NCL holds DATA until acknowledged, so this is the backpressure path.
  - WAIT_NULL (quat_comp=1): if s==p==0, set quat_comp=0 and go to WAIT_DATA. Any nonzero s is held; nothing is pushed.
- Illegal code: more than one rail high in s, in either state, on a cycle where s==p.
  - Set err_multi and increment err_count (saturates at all-ones).
  - No push, no state change. Counting is per cycle while the condition persists.
- Decode: rail0->0, rail1->1, rail2->2, rail3->3 (2-bit binary).
- Latency (rails switch cleanly just before edge k):
  - s valid after edge k+SYNC_STAGES-1; p equal after edge k+SYNC_STAGES.
  - Push and quat_comp=1 at edge k+SYNC_STAGES.
  - dout_valid=1 visible after that same edge (show-ahead FIFO).
  - NULL-to-quat_comp=0 uses the same latency.
- FIFO:
  - Show-ahead: dout always reflects the head entry. dout holds its last value when empty.
  - Simultaneous push and pop on one edge is allowed, including when full: the pop frees the slot in the same edge, so a full FIFO with dout_ready=1 accepts.
  - Pointers wrap modulo DEPTH. No overflow or underflow possible by construction.
- quat_comp is driven directly from a flop (glitch-free to the asynchronous upstream).

Test Plan:
- Reset, then init_n=1 with quat_in=0000: quat_comp=0, dout_valid=0, err_count=0 for 10 cycles.
- quat_in=0100, held until quat_comp=1, then quat_in=0000: push at edge SYNC_STAGES after the change, dout=2, dout_valid=1, quat_comp returns to 0 SYNC_STAGES edges after NULL. With dout_ready=1, dout_valid falls after one pop.
- Wavefronts 0001, 0010, 0100, 1000, each separated by NULL, dout_ready=1: output sequence 0,1,2,3 in order, no loss.
- DEPTH=4, dout_ready=0, six wavefronts:
  - Four accepted; fifth held with quat_comp staying 0.
  - dout_ready=1 for one cycle: fifth accepted on the same edge as the pop.
  - Drained order matches input order.
- quat_in=0110 for 3 cycles, then 0000: err_multi=1, err_count=2 (s==p holds for 2 of the cycles), no push, quat_comp stays 0. A single-cycle 0001 glitch is ignored (no push).
- Two words buffered, init_n pulsed low mid-wavefront: dout_valid=0 and quat_comp=0 immediately. After release, the next wavefront 1000 yields dout=3 as the only entry.

Source files
------------

// File: rtl/quat_ncl_sync_sink_if.sv
// NCL rail side (quat_in/quat_comp) plus the clocked valid/ready output and error status.
// master = the surroundings driving rails and dout_ready; slave = the sink.
interface quat_ncl_sync_sink_if #(
  parameter int ERR_W = 8
) ();
  logic [3:0]       quat_in;
  logic             quat_comp;
  logic [1:0]       dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             err_multi;
  logic [ERR_W-1:0] err_count;

  modport master (
    output quat_in, dout_ready,
    input  quat_comp, dout, dout_valid, err_multi, err_count
  );

  modport slave (
    input  quat_in, dout_ready,
    output quat_comp, dout, dout_valid, err_multi, err_count
  );
endinterface

// File: rtl/quat_ncl_sync_sink.sv
// Clocked sink for 1-of-4 NCL rails: synchronize, detect stable DATA/NULL, decode, buffer in a show-ahead FIFO.
// Push lands SYNC_STAGES edges after a clean rail change; a full FIFO withholds quat_comp, stalling upstream.
module quat_ncl_sync_sink #(
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4,
  parameter int ERR_W       = 8
) (
  input logic                  clk,
  input logic                  init_n,
  quat_ncl_sync_sink_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {WAIT_DATA = 1'b0, WAIT_NULL = 1'b1} state_t;

  logic [3:0]       sync_q [SYNC_STAGES];
  logic [3:0]       s_ahead;
  logic [3:0]       s;
  logic             stable;
  logic             onehot;
  logic             multi;
  logic [1:0]       idx;
  state_t           state_q;
  state_t           state_d;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [1:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic [1:0]       last_q;
  logic             err_multi_q;
  logic [ERR_W-1:0] err_count_q;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b0000;
    end else begin
      sync_q[0] <= bus.quat_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // The stability test compares the sample about to become s with the current s,
  // so the decision registers on the same edge the previous-sample view goes equal.
  assign s_ahead = sync_q[SYNC_STAGES-2];
  assign s       = sync_q[SYNC_STAGES-1];
  assign stable  = (s_ahead == s);
  assign multi   = ((s & (s - 4'd1)) != 4'b0000);
  assign onehot  = (s != 4'b0000) && !multi;

  always_comb begin
    idx = 2'd0;
    case (s)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign pop   = !empty && bus.dout_ready;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      WAIT_DATA: begin
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        if (stable && onehot && (!full || pop)) begin
          push    = 1'b1;
          state_d = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        if (stable && (s == 4'b0000)) state_d = WAIT_DATA;
      end
      default: state_d = WAIT_DATA;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) state_q <= WAIT_DATA;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      err_multi_q <= 1'b0;
      err_count_q <= '0;
    end else if (stable && multi) begin
      err_multi_q <= 1'b1;
      if (err_count_q != '1) err_count_q <= err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= idx;
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      last_q <= 2'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign bus.quat_comp  = (state_q == WAIT_NULL);
  assign bus.dout       = empty ? last_q : mem[rd_ptr];
  assign bus.dout_valid = !empty;
  assign bus.err_multi  = err_multi_q;
  assign bus.err_count  = err_count_q;
endmodule

// File: tb/tb_quat_ncl_sync_sink.sv
// Directed bench for quat_ncl_sync_sink: latency, ordering, backpressure, illegal codes, mid-run reset.
module tb_quat_ncl_sync_sink;
  logic clk;
  logic init_n;
  int   n_cmp;
  int   n_err;
  logic mon_en;
  logic [1:0] got [$];
  logic [1:0] exp_seq [6];

  quat_ncl_sync_sink_if #(.ERR_W(8)) bus ();

  quat_ncl_sync_sink #(.SYNC_STAGES(2), .DEPTH(4), .ERR_W(8)) dut (
    .clk    (clk),
    .init_n (init_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en && init_n && bus.dout_valid && bus.dout_ready) got.push_back(bus.dout);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full four-phase wavefront: DATA until acknowledged, then NULL until released.
  task automatic send(input logic [3:0] code, input string tag);
    int t;
    bus.quat_in = code;
    t = 0;
    while (bus.quat_comp !== 1'b1 && t < 20) begin
      tick(1);
      t++;
    end
    chk({tag, "_ack"}, 32'(bus.quat_comp), 32'd1);
    bus.quat_in = 4'b0000;
    t = 0;
    while (bus.quat_comp !== 1'b0 && t < 20) begin
      tick(1);
      t++;
    end
    chk({tag, "_rel"}, 32'(bus.quat_comp), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    mon_en = 1'b0;
    init_n = 1'b0;
    bus.quat_in = 4'b0000;
    bus.dout_ready = 1'b0;

    // Reset state
    tick(2);
    @(negedge clk);
    chk("rst_comp",  32'(bus.quat_comp),  32'd0);
    chk("rst_valid", 32'(bus.dout_valid), 32'd0);
    chk("rst_dout",  32'(bus.dout),       32'd0);
    chk("rst_multi", 32'(bus.err_multi),  32'd0);
    chk("rst_count", 32'(bus.err_count),  32'd0);
    @(posedge clk);
    #1;
    init_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("idle_comp",  32'(bus.quat_comp),  32'd0);
      chk("idle_valid", 32'(bus.dout_valid), 32'd0);
      chk("idle_count", 32'(bus.err_count),  32'd0);
    end

    // Single wavefront latency: push on the 2nd edge after the change
    bus.quat_in = 4'b0100;
    tick(1);
    chk("lat_e1_comp", 32'(bus.quat_comp), 32'd0);
    tick(1);
    chk("lat_e2_comp",  32'(bus.quat_comp),  32'd0);
    chk("lat_e2_valid", 32'(bus.dout_valid), 32'd0);
    tick(1);
    chk("lat_e3_comp",  32'(bus.quat_comp),  32'd1);
    chk("lat_e3_valid", 32'(bus.dout_valid), 32'd1);
    chk("lat_e3_dout",  32'(bus.dout),       32'd2);
    bus.quat_in = 4'b0000;
    tick(2);
    chk("null_e2_comp", 32'(bus.quat_comp), 32'd1);
    tick(1);
    chk("null_e3_comp", 32'(bus.quat_comp), 32'd0);
    bus.dout_ready = 1'b1;
    tick(1);
    bus.dout_ready = 1'b0;
    chk("pop1_valid", 32'(bus.dout_valid), 32'd0);
    chk("pop1_hold",  32'(bus.dout),       32'd2);

    // Streaming with ready high: 0,1,2,3 in order
    got.delete();
    mon_en = 1'b1;
    bus.dout_ready = 1'b1;
    send(4'b0001, "s0");
    send(4'b0010, "s1");
    send(4'b0100, "s2");
    send(4'b1000, "s3");
    tick(3);
    mon_en = 1'b0;
    bus.dout_ready = 1'b0;
    chk("stream_len", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("stream_val", 32'(got[i]), 32'(i));

    // Backpressure: four fill the FIFO, fifth waits for a pop
    exp_seq[0] = 2'd3; exp_seq[1] = 2'd2; exp_seq[2] = 2'd1;
    exp_seq[3] = 2'd0; exp_seq[4] = 2'd3; exp_seq[5] = 2'd1;
    send(4'b1000, "f0");
    send(4'b0100, "f1");
    send(4'b0010, "f2");
    send(4'b0001, "f3");
    bus.quat_in = 4'b1000;
    tick(6);
    chk("full_hold_comp", 32'(bus.quat_comp),  32'd0);
    chk("full_head",      32'(bus.dout),       32'd3);
    got.delete();
    mon_en = 1'b1;
    bus.dout_ready = 1'b1;
    tick(1);
    bus.dout_ready = 1'b0;
    chk("full_pushpop_comp", 32'(bus.quat_comp), 32'd1);
    chk("full_pushpop_head", 32'(bus.dout),      32'd2);
    send(4'b1000, "f4");
    bus.dout_ready = 1'b1;
    send(4'b0010, "f5");
    tick(8);
    mon_en = 1'b0;
    bus.dout_ready = 1'b0;
    chk("drain_len", 32'(got.size()), 32'd6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk("drain_val", 32'(got[i]), 32'(exp_seq[i]));
    chk("drain_empty", 32'(bus.dout_valid), 32'd0);

    // Illegal two-rail code for three cycles, then a one-cycle glitch
    bus.quat_in = 4'b0110;
    tick(3);
    bus.quat_in = 4'b0000;
    tick(4);
    chk("ill_multi", 32'(bus.err_multi),  32'd1);
    chk("ill_count", 32'(bus.err_count),  32'd2);
    chk("ill_valid", 32'(bus.dout_valid), 32'd0);
    chk("ill_comp",  32'(bus.quat_comp),  32'd0);
    bus.quat_in = 4'b0001;
    tick(1);
    bus.quat_in = 4'b0000;
    tick(4);
    chk("glitch_valid", 32'(bus.dout_valid), 32'd0);
    chk("glitch_comp",  32'(bus.quat_comp),  32'd0);
    chk("glitch_count", 32'(bus.err_count),  32'd2);

    // Mid-operation reset with buffered words and a wavefront in flight
    send(4'b0001, "r0");
    send(4'b0010, "r1");
    bus.quat_in = 4'b0100;
    tick(3);
    chk("pre_rst_comp",  32'(bus.quat_comp),  32'd1);
    chk("pre_rst_valid", 32'(bus.dout_valid), 32'd1);
    #2;
    init_n = 1'b0;
    #1;
    chk("arst_comp",  32'(bus.quat_comp),  32'd0);
    chk("arst_valid", 32'(bus.dout_valid), 32'd0);
    chk("arst_count", 32'(bus.err_count),  32'd0);
    chk("arst_multi", 32'(bus.err_multi),  32'd0);
    bus.quat_in = 4'b0000;
    tick(2);
    init_n = 1'b1;
    tick(3);
    chk("post_rst_valid", 32'(bus.dout_valid), 32'd0);
    send(4'b1000, "r2");
    chk("post_rst_head",  32'(bus.dout),       32'd3);
    chk("post_rst_vld",   32'(bus.dout_valid), 32'd1);
    bus.dout_ready = 1'b1;
    tick(1);
    bus.dout_ready = 1'b0;
    chk("post_rst_only", 32'(bus.dout_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
